// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef logic [IDX_W-1:0]   arb_idx_t;
    typedef logic [NUM_REQ-1:0] arb_vec_t;

    // Turns an encoded requester index into its one-hot grant vector.
    function automatic arb_vec_t idx_to_onehot(input arb_idx_t idx);
        arb_vec_t vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter_4to2_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_4to2_if;
    import arb_pkg::*;

    arb_vec_t req;
    arb_vec_t gnt;
    arb_idx_t gnt_idx;
    logic     gnt_valid;
    arb_idx_t last_idx;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  last_idx
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output last_idx
    );

endinterface

// File: rtl/rr_prio_encoder_4to2.sv
// Combinational round-robin winner picker: the first unmasked request found
// scanning upward from the slot just after the pointer, wrapping 3 -> 0.
module rr_prio_encoder_4to2
    import arb_pkg::*;
(
    input  arb_vec_t req,
    input  arb_vec_t mask,
    input  arb_idx_t ptr,
    output arb_idx_t idx,
    output logic     valid
);

    arb_vec_t avail;

    // Scan from farthest to nearest slot so the nearest candidate after ptr wins.
    always_comb begin
        arb_idx_t cand;
        avail = req & ~mask;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + arb_idx_t'(1) + arb_idx_t'(k);
            if (avail[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4to2.sv
// Round-robin arbiter for four requesters with a registered one-hot grant,
// encoded index, valid flag and an optional hold limit that forces rotation.
module rr_arbiter_4to2 #(
    parameter int NUM_REQ  = arb_pkg::NUM_REQ,
    parameter int IDX_W    = arb_pkg::IDX_W,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_4to2_if.slave  bus
);
    import arb_pkg::*;

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    generate
        if (NUM_REQ != 4 || IDX_W != 2) begin : g_bad_size
            $error("rr_arbiter_4to2 supports exactly 4 requesters with a 2-bit index");
        end
    endgenerate

    arb_state_t        state_q, state_n;
    arb_vec_t          gnt_q, gnt_n;
    arb_idx_t          gnt_idx_q, gnt_idx_n;
    arb_idx_t          last_q, last_n;
    logic [HOLD_W-1:0] hold_q, hold_n;

    arb_vec_t          enc_mask;
    arb_idx_t          enc_idx;
    logic              enc_valid;

    // The current holder is masked so a release or timeout always moves on.
    assign enc_mask = (state_q == GRANT) ? idx_to_onehot(gnt_idx_q) : '0;

    rr_prio_encoder_4to2 u_enc (
        .req   (bus.req),
        .mask  (enc_mask),
        .ptr   (last_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= arb_idx_t'(NUM_REQ - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            gnt_idx_q <= gnt_idx_n;
            last_q    <= last_n;
            hold_q    <= hold_n;
        end
    end

    // Next-state logic: grant, hold, release, or forced rotation on hold limit.
    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        gnt_idx_n = gnt_idx_q;
        last_n    = last_q;
        hold_n    = hold_q;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_n   = GRANT;
                    gnt_n     = idx_to_onehot(enc_idx);
                    gnt_idx_n = enc_idx;
                    last_n    = enc_idx;
                    hold_n    = '0;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_idx_q]) begin
                    if (enc_valid) begin
                        gnt_n     = idx_to_onehot(enc_idx);
                        gnt_idx_n = enc_idx;
                        last_n    = enc_idx;
                        hold_n    = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        hold_n  = '0;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LIMIT) begin
                    if (enc_valid) begin
                        gnt_n     = idx_to_onehot(enc_idx);
                        gnt_idx_n = enc_idx;
                        last_n    = enc_idx;
                        hold_n    = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.last_idx  = last_q;

endmodule

// File: tb/tb_rr_arbiter_4to2.sv
// Directed bench for rr_arbiter_4to2: reset, single requester, rotation,
// hold-limit timeout, release with competing request, and async reset mid-grant.
module tb_rr_arbiter_4to2;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    rr_arbiter_4to2_if bus ();

    rr_arbiter_4to2 #(
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int cycles);
        bus.req = r;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed test sequence.
    initial begin
        int order [5];
        order        = '{0, 1, 2, 3, 0};
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.req      = 4'b1111;

        // T1: reset with all requesting, then first grant to requester 0.
        repeat (2) @(negedge clk);
        checkOutput("t1_rst_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("t1_rst_valid", 32'(bus.gnt_valid), 32'h0);
        checkOutput("t1_rst_last", 32'(bus.last_idx), 32'h3);
        checkOutput("t1_rst_idx", 32'(bus.gnt_idx), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("t1_no_gnt_after_rst", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        checkOutput("t1_first_gnt", 32'(bus.gnt), 32'h1);
        checkOutput("t1_first_valid", 32'(bus.gnt_valid), 32'h1);
        checkOutput("t1_first_last", 32'(bus.last_idx), 32'h0);

        // T2: single requester 2 gets grant, then releases to idle.
        doReset();
        applyStimulus(4'b0100, 1);
        checkOutput("t2_gnt", 32'(bus.gnt), 32'h4);
        checkOutput("t2_idx", 32'(bus.gnt_idx), 32'h2);
        checkOutput("t2_valid", 32'(bus.gnt_valid), 32'h1);
        checkOutput("t2_last", 32'(bus.last_idx), 32'h2);
        applyStimulus(4'b0000, 1);
        checkOutput("t2_rel_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("t2_rel_valid", 32'(bus.gnt_valid), 32'h0);
        checkOutput("t2_rel_idx_kept", 32'(bus.gnt_idx), 32'h2);

        // T3: everyone requesting; holders release after two cycles in turn.
        doReset();
        applyStimulus(4'b1111, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_gnt", 32'(bus.gnt), 32'(oh(order[i])));
            checkOutput("t3_idx", 32'(bus.gnt_idx), 32'(order[i]));
            if (i < 4) begin
                @(negedge clk);
                checkOutput("t3_hold", 32'(bus.gnt), 32'(oh(order[i])));
                applyStimulus(4'b1111 & ~oh(order[i]), 1);
                bus.req = 4'b1111;
            end
        end

        // T4: two persistent requesters alternate every 8 cycles.
        doReset();
        applyStimulus(4'b0011, 1);
        for (int c = 1; c <= 24; c++) begin
            checkOutput("t4_alt_gnt", 32'(bus.gnt), (((c - 1) / 8) % 2 == 0) ? 32'h1 : 32'h2);
            if (c < 24) @(negedge clk);
        end
        // Lone requester at the hold limit keeps the grant indefinitely.
        bus.req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("t4_alone_gnt", 32'(bus.gnt), 32'h1);
        end

        // T5: holder 1 releases while 3 requests, then re-raises; 3 keeps grant.
        doReset();
        applyStimulus(4'b0010, 1);
        checkOutput("t5_gnt1", 32'(bus.gnt), 32'h2);
        applyStimulus(4'b1000, 1);
        checkOutput("t5_switch_gnt", 32'(bus.gnt), 32'h8);
        checkOutput("t5_switch_idx", 32'(bus.gnt_idx), 32'h3);
        applyStimulus(4'b1010, 2);
        checkOutput("t5_keep_gnt", 32'(bus.gnt), 32'h8);

        // T6: async reset between edges while requester 3 holds the grant.
        doReset();
        applyStimulus(4'b1000, 1);
        checkOutput("t6_pre_gnt", 32'(bus.gnt), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("t6_async_valid", 32'(bus.gnt_valid), 32'h0);
        checkOutput("t6_async_last", 32'(bus.last_idx), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t6_no_gnt_after_rst", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        checkOutput("t6_regrant_gnt", 32'(bus.gnt), 32'h8);
        checkOutput("t6_regrant_idx", 32'(bus.gnt_idx), 32'h3);
        checkOutput("t6_regrant_valid", 32'(bus.gnt_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
